rsa_io_ctrl: RTL and testbench
==============================

RSA_IO_CTRL -- requirements
Module: rsa_io_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2000000, the WAIT watchdog limit (used only with RSA_IO_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports s_valid in 1, s_ready out 1, s_data in 32, s_sel in 3, s_last in 1: the operand word input stream.
- s_sel codes: 0 modulus, 1 Rmodm, 2 Rsquaredmodm, 3 exponent, 4 x.
REQ-005 SHALL have ports cmd_start in 1 and cmd_mul in 1: the launch command; cmd_mul selects multiplication-only mode.
REQ-006 SHALL have ports modulus, rmodm, rsquaredmodm, exponent and x, each out 512: operands for the exponentiation stage.
REQ-007 SHALL have ports start_exp out 1, multiplication_enable out 1, exp_done in 1 and exp_result in 512: the exponentiation-stage handshake.
REQ-008 SHALL have ports m_valid out 1, m_ready in 1, m_data out 32 and m_last out 1: the result word output stream.
REQ-009 SHALL have ports busy out 1 and err out 1 (err is sticky).

Function
REQ-010 SHALL implement FSM states IDLE, LAUNCH, WAIT and DRAIN.
REQ-011 SHALL drive s_ready=1 only in IDLE; a word transfers when s_valid&&s_ready.
REQ-012 SHALL load each operand as 16 words, least-significant first, shifting into bits [511:480] so that word 0 ends at [31:0].
REQ-013 SHALL count words per operand (0..15) and set the operand's loaded bit when word 15 arrives with s_last=1.
REQ-014 SHALL, when s_last arrives at count!=15, accept the word, set err, reset the counter and clear that loaded bit.
- Same handling when s_sel changes at count!=0, or when s_sel>4.
REQ-015 SHALL, on cmd_start in IDLE, check the required loaded mask.
- cmd_mul=0 requires all five operands; cmd_mul=1 requires modulus, x and rsquaredmodm.
- Incomplete mask: set err, stay IDLE.
REQ-016 SHALL, on an accepted cmd_start, latch cmd_mul into multiplication_enable and go to LAUNCH.
- start_exp is high exactly one cycle (the LAUNCH cycle), one cycle after cmd_start.
REQ-017 SHALL hold all operand outputs and multiplication_enable stable from LAUNCH until return to IDLE.
REQ-018 SHALL, in WAIT, capture exp_result into the result register on the first cycle exp_done=1 and go to DRAIN.
- exp_done is level-sensitive and may last one cycle only.
REQ-019 SHALL, in DRAIN, present result words 0..15 (LSW first) with m_valid=1.
- A word advances only on m_valid&&m_ready; data stays stable while stalled.
- m_last=1 with word 15; after it transfers, go to IDLE.
REQ-020 SHALL drive busy=1 in LAUNCH, WAIT and DRAIN.
REQ-021 SHALL clear all loaded bits on return to IDLE, so each run requires a fresh load.
REQ-022 SHALL ignore cmd_start outside IDLE, and ignore exp_done outside WAIT.
REQ-023 SHALL clear err only by reset or by an accepted cmd_start.

Reset
REQ-024 SHALL, on resetn=0 at any time including mid-run, asynchronously return to IDLE.
- Cleared: all operand, result and counter registers, loaded bits, start_exp, multiplication_enable, m_valid, m_last, busy and err.
- s_ready=1 from the first clock edge after reset release.

Configuration
REQ-025 SHALL, with RSA_IO_TIMEOUT_EN defined, count WAIT cycles and, on reaching TIMEOUT_CYCLES without exp_done, set err and go to IDLE without driving m_valid.
- Without the macro: no counter, and WAIT is exited only on exp_done.

Structure
REQ-026 SHALL take the shared package rsa_io_pkg to hold OP_W=512, WORD_W=32, WORDS=16, the operand-id enum and the FSM state enum.
REQ-027 SHALL place the 512-to-32 result serializer (word counter, m_last generation) in sub-module rsa_io_ser.

Verification
REQ-028 SHALL cover: five operands loaded (word k of operand i = 0x100*i+k), cmd_start, cmd_mul=0 -> start_exp one cycle later for one cycle; exponent[31:0]=0x300, modulus[511:480]=0x00F.
REQ-029 SHALL cover: exp_done pulse of one cycle with exp_result=512'h1 -> 16 words out, word0=0x1, words 1..15=0, m_last on word 15, then IDLE.
REQ-030 SHALL cover: m_ready toggled 1/0 each cycle during DRAIN -> identical word sequence with no loss or duplication.
REQ-031 SHALL cover: s_last on word 7 of exponent -> err=1; a following cmd_start with cmd_mul=0 stays in IDLE with start_exp=0.
REQ-032 SHALL cover: cmd_mul=1 with only modulus, x and Rsquaredmodm loaded -> multiplication_enable=1 and start_exp pulses.
REQ-033 SHALL cover: resetn low during WAIT -> all outputs 0 and busy=0; with RSA_IO_TIMEOUT_EN and TIMEOUT_CYCLES=100, no exp_done -> err=1 at WAIT cycle 100.

Source files
------------

// File: rtl/rsa_io_pkg.sv
// Shared sizes, operand ids and controller state encoding for the RSA I/O controller.
package rsa_io_pkg;

   localparam int unsigned OP_W    = 512;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned WORDS   = 16;
   localparam int unsigned NUM_OPS = 5;

   typedef enum logic [2:0] {
      OpModulus  = 3'd0,
      OpRmodm    = 3'd1,
      OpRsquared = 3'd2,
      OpExponent = 3'd3,
      OpX        = 3'd4
   } op_id_e;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLaunch = 2'd1,
      StWait   = 2'd2,
      StDrain  = 2'd3
   } state_e;

   // Required loaded masks, bit index = operand id.
   localparam logic [NUM_OPS-1:0] MASK_EXP = 5'b11111;
   localparam logic [NUM_OPS-1:0] MASK_MUL = 5'b10101;

   // Ids above OpX shift the bit out, giving an empty mask.
   function automatic logic [NUM_OPS-1:0] op_bit(input logic [2:0] sel);
      return 5'b00001 << sel;
   endfunction

endpackage

// File: rtl/rsa_io_ser.sv
// 512-to-32 result serializer: holds the captured result and streams it out LSW first.
module rsa_io_ser
   import rsa_io_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              load,
   input  logic [OP_W-1:0]   data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [WORD_W-1:0] m_data,
   output logic              m_last,
   output logic              done
);

   logic [OP_W-1:0] res_q;
   logic [3:0]      idx_q;
   logic            valid_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         res_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         res_q   <= data;
         idx_q   <= '0;
         valid_q <= 1'b1;
      end else if (valid_q && m_ready) begin
         res_q <= res_q >> WORD_W;
         idx_q <= idx_q + 4'd1;
         if (idx_q == 4'(WORDS - 1)) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign m_valid = valid_q;
   assign m_data  = res_q[WORD_W-1:0];
   assign m_last  = valid_q && (idx_q == 4'(WORDS - 1));
   assign done    = m_valid && m_ready && m_last;

endmodule

// File: rtl/rsa_io_ctrl.sv
// Operand loader / launch / result drain controller around the exponentiation stage.
// Optional WAIT watchdog enabled by defining RSA_IO_TIMEOUT_EN.
module rsa_io_ctrl
   import rsa_io_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data,
   input  logic [2:0]        s_sel,
   input  logic              s_last,
   input  logic              cmd_start,
   input  logic              cmd_mul,
   output logic [OP_W-1:0]   modulus,
   output logic [OP_W-1:0]   rmodm,
   output logic [OP_W-1:0]   rsquaredmodm,
   output logic [OP_W-1:0]   exponent,
   output logic [OP_W-1:0]   x,
   output logic              start_exp,
   output logic              multiplication_enable,
   input  logic              exp_done,
   input  logic [OP_W-1:0]   exp_result,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [WORD_W-1:0] m_data,
   output logic              m_last,
   output logic              busy,
   output logic              err
);

   state_e               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [2:0]           sel_q, sel_d;
   logic [NUM_OPS-1:0]   loaded_q, loaded_d;
   logic                 err_q, err_d;
   logic                 mul_en_q, mul_en_d;
   logic                 rdy_q;
   logic [OP_W-1:0]      op_q [NUM_OPS];
   logic                 in_fire, shift_en, res_load, ser_done, tmo_hit;
   logic [NUM_OPS-1:0]   need;

   assign in_fire = s_valid && s_ready;
   assign need    = cmd_mul ? MASK_MUL : MASK_EXP;

`ifdef RSA_IO_TIMEOUT_EN
   logic [31:0] tmo_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tmo_q <= '0;
      end else if (state_q == StWait) begin
         tmo_q <= tmo_q + 32'd1;
      end else begin
         tmo_q <= '0;
      end
   end

   assign tmo_hit = (tmo_q == 32'(TIMEOUT_CYCLES - 1));
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
   assign tmo_hit        = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      loaded_d = loaded_q;
      err_d    = err_q;
      mul_en_d = mul_en_q;
      shift_en = 1'b0;
      res_load = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_fire) begin
               if (s_sel > 3'd4) begin
                  err_d = 1'b1;
                  cnt_d = '0;
               end else begin
                  shift_en = 1'b1;
                  sel_d    = s_sel;
                  if ((cnt_q != 4'd0) && (s_sel != sel_q)) begin
                     // Operand switched mid-load: both operands are now suspect.
                     err_d    = 1'b1;
                     cnt_d    = '0;
                     loaded_d = loaded_q & ~(op_bit(s_sel) | op_bit(sel_q));
                  end else if (cnt_q == 4'(WORDS - 1)) begin
                     cnt_d = '0;
                     if (s_last) begin
                        loaded_d = loaded_q | op_bit(s_sel);
                     end else begin
                        err_d    = 1'b1;
                        loaded_d = loaded_q & ~op_bit(s_sel);
                     end
                  end else if (s_last) begin
                     err_d    = 1'b1;
                     cnt_d    = '0;
                     loaded_d = loaded_q & ~op_bit(s_sel);
                  end else begin
                     cnt_d    = cnt_q + 4'd1;
                     loaded_d = loaded_q & ~op_bit(s_sel);
                  end
               end
            end
            if (cmd_start) begin
               if ((loaded_q & need) == need) begin
                  err_d    = 1'b0;
                  mul_en_d = cmd_mul;
                  state_d  = StLaunch;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StLaunch: state_d = StWait;
         StWait: begin
            if (exp_done) begin
               res_load = 1'b1;
               state_d  = StDrain;
            end else if (tmo_hit) begin
               err_d    = 1'b1;
               state_d  = StIdle;
               loaded_d = '0;
               cnt_d    = '0;
            end
         end
         StDrain: begin
            if (ser_done) begin
               state_d  = StIdle;
               loaded_d = '0;
               cnt_d    = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         sel_q    <= '0;
         loaded_q <= '0;
         err_q    <= 1'b0;
         mul_en_q <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         loaded_q <= loaded_d;
         err_q    <= err_d;
         mul_en_q <= mul_en_d;
         rdy_q    <= 1'b1;
      end
   end

   // Words enter at the top so the first (least significant) word ends at [31:0].
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_OPS; i++) begin
            op_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_OPS; i++) begin
            if (shift_en && (s_sel == 3'(i))) begin
               op_q[i] <= {s_data, op_q[i][OP_W-1:WORD_W]};
            end
         end
      end
   end

   rsa_io_ser u_ser (
      .clk     (clk),
      .resetn  (resetn),
      .load    (res_load),
      .data    (exp_result),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_last  (m_last),
      .done    (ser_done)
   );

   assign modulus               = op_q[OpModulus];
   assign rmodm                 = op_q[OpRmodm];
   assign rsquaredmodm          = op_q[OpRsquared];
   assign exponent              = op_q[OpExponent];
   assign x                     = op_q[OpX];
   assign s_ready               = rdy_q && (state_q == StIdle);
   assign start_exp             = (state_q == StLaunch);
   assign busy                  = (state_q != StIdle);
   assign multiplication_enable = mul_en_q;
   assign err                   = err_q;

endmodule

// File: tb/tb_rsa_io_ctrl.sv
// Directed + randomized bench for rsa_io_ctrl with a word-level operand/result model.
module tb_rsa_io_ctrl;

   localparam int unsigned TMO = 100;

   logic         clk = 1'b0;
   logic         resetn;
   logic         s_valid, s_ready, s_last;
   logic [31:0]  s_data;
   logic [2:0]   s_sel;
   logic         cmd_start, cmd_mul;
   logic [511:0] modulus, rmodm, rsquaredmodm, exponent, x;
   logic         start_exp, multiplication_enable, exp_done;
   logic [511:0] exp_result;
   logic         m_valid, m_ready, m_last, busy, err;
   logic [31:0]  m_data;

   int           tests = 0;
   int           fails = 0;
   logic [511:0] model_op [5];
   logic [511:0] r;

   rsa_io_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk                   (clk),
      .resetn                (resetn),
      .s_valid               (s_valid),
      .s_ready               (s_ready),
      .s_data                (s_data),
      .s_sel                 (s_sel),
      .s_last                (s_last),
      .cmd_start             (cmd_start),
      .cmd_mul               (cmd_mul),
      .modulus               (modulus),
      .rmodm                 (rmodm),
      .rsquaredmodm          (rsquaredmodm),
      .exponent              (exponent),
      .x                     (x),
      .start_exp             (start_exp),
      .multiplication_enable (multiplication_enable),
      .exp_done              (exp_done),
      .exp_result            (exp_result),
      .m_valid               (m_valid),
      .m_ready               (m_ready),
      .m_data                (m_data),
      .m_last                (m_last),
      .busy                  (busy),
      .err                   (err)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] sel, input logic [31:0] d, input logic last);
      s_valid = 1'b1;
      s_sel   = sel;
      s_data  = d;
      s_last  = last;
      @(negedge clk);
      check("s_ready_idle", s_ready, 1'b1);
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Sends words 0..last_at of v; only a full 16-word load updates the model.
   task automatic load(input int id, input logic [511:0] v, input int last_at);
      for (int k = 0; k <= last_at; k++) begin
         send(3'(id), v[32*k +: 32], k == last_at);
      end
      if (last_at == 15) model_op[id] = v;
   endtask

   function automatic logic [511:0] pattern(input int i);
      logic [511:0] v;
      for (int k = 0; k < 16; k++) v[32*k +: 32] = 32'(256 * i + k);
      return v;
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] v;
      for (int k = 0; k < 16; k++) v[32*k +: 32] = $urandom;
      return v;
   endfunction

   task automatic check_ops(input string tag);
      check({tag, "_modulus"}, modulus, model_op[0]);
      check({tag, "_rmodm"}, rmodm, model_op[1]);
      check({tag, "_rsq"}, rsquaredmodm, model_op[2]);
      check({tag, "_exponent"}, exponent, model_op[3]);
      check({tag, "_x"}, x, model_op[4]);
   endtask

   task automatic start(input logic mul);
      cmd_start = 1'b1;
      cmd_mul   = mul;
      tick();
      cmd_start = 1'b0;
      cmd_mul   = 1'b0;
   endtask

   task automatic finish_exp(input logic [511:0] res);
      exp_result = res;
      exp_done   = 1'b1;
      tick();
      exp_done   = 1'b0;
      exp_result = rand512();
   endtask

   // Expected word k of the result is res[32k+31:32k]; m_last only with word 15.
   task automatic drain(input logic [511:0] res, input bit toggle);
      int got = 0;
      int cyc = 0;
      while (got < 16 && cyc < 200) begin
         m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         @(negedge clk);
         if (m_valid) begin
            check("drain_word", m_data, res[32*got +: 32]);
            check("drain_last", m_last, got == 15);
            if (m_ready) got++;
         end
         tick();
         cyc++;
      end
      m_ready = 1'b0;
      check("drain_count", got, 16);
      check("drain_idle_busy", busy, 1'b0);
      check("drain_idle_mvalid", m_valid, 1'b0);
      check("drain_idle_ready", s_ready, 1'b1);
   endtask

   initial begin
      resetn = 1'b0; s_valid = 1'b0; s_data = '0; s_sel = '0; s_last = 1'b0;
      cmd_start = 1'b0; cmd_mul = 1'b0; exp_done = 1'b0; exp_result = '0; m_ready = 1'b0;
      for (int i = 0; i < 5; i++) model_op[i] = '0;

      #12;
      check("rst_busy", busy, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_mvalid", m_valid, 1'b0);
      check("rst_start", start_exp, 1'b0);
      check_ops("rst");
      @(negedge clk);
      resetn = 1'b1;
      tick();
      check("rst_ready_after", s_ready, 1'b1);

      // Directed patterned load and exponentiation run.
      for (int i = 0; i < 5; i++) load(i, pattern(i), 15);
      check("exp_lsw", exponent[31:0], 32'h300);
      check("mod_msw", modulus[511:480], 32'h00F);
      check_ops("pat");
      exp_result = '1;
      exp_done   = 1'b1;
      tick();
      exp_done   = 1'b0;
      check("done_in_idle_mvalid", m_valid, 1'b0);
      check("done_in_idle_busy", busy, 1'b0);
      start(1'b0);
      check("launch_start", start_exp, 1'b1);
      check("launch_busy", busy, 1'b1);
      check("launch_mul", multiplication_enable, 1'b0);
      check("launch_err", err, 1'b0);
      tick();
      check("wait_start_low", start_exp, 1'b0);
      check("wait_busy", busy, 1'b1);
      tick();
      check_ops("wait_stable");
      finish_exp(512'h1);
      drain(512'h1, 1'b0);

      // Randomized operands and results with a stalling consumer.
      for (int it = 0; it < 2; it++) begin
         for (int i = 0; i < 5; i++) load(i, rand512(), 15);
         check_ops("rnd");
         start(1'b0);
         check("rnd_start", start_exp, 1'b1);
         repeat ($urandom_range(1, 5)) tick();
         r = rand512();
         finish_exp(r);
         check_ops("rnd_drain_stable");
         drain(r, 1'b1);
      end

      // Early s_last on exponent, then a rejected start.
      load(0, rand512(), 15);
      load(4, rand512(), 15);
      load(2, rand512(), 15);
      load(3, rand512(), 7);
      check("early_last_err", err, 1'b1);
      start(1'b0);
      check("reject_start", start_exp, 1'b0);
      check("reject_busy", busy, 1'b0);
      check("reject_err", err, 1'b1);

      // Multiplication-only launch with modulus, x and Rsquaredmodm.
      start(1'b1);
      check("mul_start", start_exp, 1'b1);
      check("mul_en", multiplication_enable, 1'b1);
      check("mul_err_cleared", err, 1'b0);
      tick();
      check("mul_start_low", start_exp, 1'b0);
      r = rand512();
      finish_exp(r);
      drain(r, 1'b0);

      // Operand switch mid-load.
      send(3'd1, 32'h1234, 1'b0);
      check("sel_switch_pre", err, 1'b0);
      send(3'd2, 32'h5678, 1'b0);
      check("sel_switch_err", err, 1'b1);

      // Reset during WAIT.
      for (int i = 0; i < 5; i++) load(i, pattern(i), 15);
      start(1'b0);
      tick();
      tick();
      check("pre_rst_busy", busy, 1'b1);
      resetn = 1'b0;
      #2;
      for (int i = 0; i < 5; i++) model_op[i] = '0;
      check_ops("midrst");
      check("midrst_busy", busy, 1'b0);
      check("midrst_err", err, 1'b0);
      check("midrst_start", start_exp, 1'b0);
      check("midrst_mul", multiplication_enable, 1'b0);
      check("midrst_mvalid", m_valid, 1'b0);
      check("midrst_mlast", m_last, 1'b0);
      check("midrst_mdata", m_data, 32'h0);
      check("midrst_ready", s_ready, 1'b0);
      @(negedge clk);
      resetn = 1'b1;
      tick();
      check("midrst_ready_after", s_ready, 1'b1);

`ifdef RSA_IO_TIMEOUT_EN
      load(0, rand512(), 15);
      load(2, rand512(), 15);
      load(4, rand512(), 15);
      start(1'b1);
      check("tmo_start", start_exp, 1'b1);
      repeat (TMO) tick();
      check("tmo_cycle100_busy", busy, 1'b1);
      check("tmo_cycle100_err", err, 1'b0);
      tick();
      check("tmo_idle_busy", busy, 1'b0);
      check("tmo_err", err, 1'b1);
      check("tmo_mvalid", m_valid, 1'b0);
      repeat (3) tick();
      check("tmo_no_mvalid", m_valid, 1'b0);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      tick();
`endif

      // Invalid operand id.
      check("badsel_pre", err, 1'b0);
      send(3'd5, 32'hDEAD, 1'b0);
      check("badsel_err", err, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
